// File: rtl/bridge_pkg.sv
// Shared types for the bridge switch controller: command codes, gate patterns,
// FSM states and the command-to-pattern decode.
package bridge_pkg;

  localparam int N_ERR = 6;

  typedef enum logic [2:0] {
    CMD_PAUSE     = 3'd0,
    CMD_PLUS      = 3'd1,
    CMD_MINUS     = 3'd2,
    CMD_BALLAST_P = 3'd3,
    CMD_BALLAST_N = 3'd4,
    CMD_START     = 3'd5,
    CMD_SHUTDOWN  = 3'd6,
    CMD_DISCHARGE = 3'd7
  } cmd_e;

  typedef struct packed {
    logic [3:0] top;
    logic [3:0] bot;
    logic       plus;
    logic       minus;
    logic       pause_p;
    logic       pause_n;
  } pat_t;

  typedef enum logic [1:0] {IDLE, DEAD, DRIVE, FAULT} state_e;

  localparam pat_t PAT_OFF = '0;

  function automatic pat_t cmd_to_pat(input cmd_e c);
    pat_t p;
    p = PAT_OFF;
    case (c)
      CMD_PLUS:      begin p.top = 4'b0001; p.bot = 4'b0010; p.plus    = 1'b1; end
      CMD_MINUS:     begin p.top = 4'b0010; p.bot = 4'b0001; p.minus   = 1'b1; end
      CMD_BALLAST_P: begin p.top = 4'b0100; p.bot = 4'b1000; p.pause_p = 1'b1; end
      CMD_BALLAST_N: begin p.top = 4'b1000; p.bot = 4'b0100; p.pause_n = 1'b1; end
      default:       p = PAT_OFF;
    endcase
    return p;
  endfunction

  // SHUTDOWN drives exactly like PAUSE outside of FAULT.
  function automatic cmd_e cmd_norm(input cmd_e c);
    return (c == CMD_SHUTDOWN) ? CMD_PAUSE : c;
  endfunction

  function automatic logic is_pattern_cmd(input cmd_e c);
    return !((c == CMD_START) || (c == CMD_DISCHARGE));
  endfunction

endpackage

// File: rtl/bridge_switch_ctrl_if.sv
// Command, fault and gate-drive bundle between the command decoder, the
// bridge switch controller and the output pins.
interface bridge_switch_ctrl_if;

  logic                          enable;
  logic                          cmd_valid;
  logic [2:0]                    cmd;
  logic [bridge_pkg::N_ERR-1:0]  err_n;
  logic [3:0]                    top;
  logic [3:0]                    bot;
  logic                          plus;
  logic                          minus;
  logic                          pause_p;
  logic                          pause_n;
  logic                          busy;
  logic                          fault;
  logic [bridge_pkg::N_ERR-1:0]  fault_src;
  logic                          cmd_ignored;

  modport master (
    output enable, cmd_valid, cmd, err_n,
    input  top, bot, plus, minus, pause_p, pause_n,
    input  busy, fault, fault_src, cmd_ignored
  );

  modport slave (
    input  enable, cmd_valid, cmd, err_n,
    output top, bot, plus, minus, pause_p, pause_n,
    output busy, fault, fault_src, cmd_ignored
  );

endinterface

// File: rtl/err_filter.sv
// Debounce for one active-low fault input: asserts once ERR_FILT consecutive
// low samples have been seen, including the current one.
module err_filter #(
  parameter int ERR_FILT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_err_n,
  output logic o_filt
);

  localparam int CW = (ERR_FILT > 1) ? $clog2(ERR_FILT) : 1;
  localparam logic [CW-1:0] SAT = CW'(ERR_FILT - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_err_n) begin
      r_cnt <= '0;
    end else if (r_cnt != SAT) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // The current low sample completes the run, so the FSM reacts on that edge.
  assign o_filt = !i_err_n && (r_cnt == SAT);

endmodule

// File: rtl/bridge_switch_ctrl.sv
// Sequences bridge gate patterns with enforced all-off dead time, and latches
// filtered faults until an explicit SHUTDOWN with no error active.
module bridge_switch_ctrl
  import bridge_pkg::*;
#(
  parameter int DEADTIME_CYC = 50,
  parameter int ERR_FILT     = 4
) (
  input logic           clk,
  input logic           rst,
  bridge_switch_ctrl_if.slave bus
);

  localparam int CNT_W = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEADTIME_CYC - 1);

  logic [N_ERR-1:0] w_filt;
  logic             w_any_err;
  cmd_e             w_cmd;
  cmd_e             w_cmd_norm;
  logic             w_act;
  cmd_e             w_tgt_next;

  state_e           r_state;
  cmd_e             r_target;
  cmd_e             r_current;
  logic [CNT_W-1:0] r_cnt;
  pat_t             r_pat;
  logic             r_busy;
  logic             r_fault;
  logic [N_ERR-1:0] r_fault_src;
  logic             r_cmd_ignored;

  for (genvar g = 0; g < N_ERR; g++) begin : g_filt
    err_filter #(.ERR_FILT(ERR_FILT)) u_err_filter (
      .clk     (clk),
      .rst     (rst),
      .i_err_n (bus.err_n[g]),
      .o_filt  (w_filt[g])
    );
  end

  assign w_any_err  = |w_filt;
  assign w_cmd      = cmd_e'(bus.cmd);
  assign w_cmd_norm = cmd_norm(w_cmd);
  assign w_act      = bus.cmd_valid && is_pattern_cmd(w_cmd);
  assign w_tgt_next = w_act ? w_cmd_norm : r_target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_target      <= CMD_PAUSE;
      r_current     <= CMD_PAUSE;
      r_cnt         <= '0;
      r_pat         <= PAT_OFF;
      r_busy        <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_src   <= '0;
      r_cmd_ignored <= 1'b0;
    end else begin
      r_cmd_ignored <= 1'b0;
      if (w_any_err) begin
        // Fault wins over any command arriving in the same cycle.
        r_state       <= FAULT;
        r_pat         <= PAT_OFF;
        r_busy        <= 1'b0;
        r_fault       <= 1'b1;
        r_fault_src   <= r_fault_src | w_filt;
        r_current     <= CMD_PAUSE;
        r_cnt         <= '0;
        r_cmd_ignored <= bus.cmd_valid;
      end else if (r_state == FAULT) begin
        if (bus.cmd_valid) begin
          if (w_cmd == CMD_SHUTDOWN) begin
            r_state     <= IDLE;
            r_fault     <= 1'b0;
            r_fault_src <= '0;
            r_target    <= CMD_PAUSE;
          end else begin
            r_cmd_ignored <= 1'b1;
          end
        end
      end else if (!bus.enable) begin
        r_state       <= IDLE;
        r_pat         <= PAT_OFF;
        r_busy        <= 1'b0;
        r_current     <= CMD_PAUSE;
        r_target      <= CMD_PAUSE;
        r_cnt         <= '0;
        r_cmd_ignored <= bus.cmd_valid && (w_cmd_norm != CMD_PAUSE);
      end else begin
        if (bus.cmd_valid && !w_act) r_cmd_ignored <= 1'b1;
        case (r_state)
          IDLE: begin
            if (w_act && (w_cmd_norm != CMD_PAUSE)) begin
              r_target <= w_cmd_norm;
              r_cnt    <= CNT_LOAD;
              r_busy   <= 1'b1;
              r_state  <= DEAD;
            end
          end
          DEAD: begin
            // A command here only retargets; the dead-time count keeps running.
            r_target <= w_tgt_next;
            if (r_cnt == '0) begin
              r_busy <= 1'b0;
              if (w_tgt_next == CMD_PAUSE) begin
                r_state   <= IDLE;
                r_current <= CMD_PAUSE;
              end else begin
                r_state   <= DRIVE;
                r_current <= w_tgt_next;
                r_pat     <= cmd_to_pat(w_tgt_next);
              end
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          DRIVE: begin
            if (w_act && (w_cmd_norm != r_current)) begin
              r_target <= w_cmd_norm;
              r_cnt    <= CNT_LOAD;
              r_busy   <= 1'b1;
              r_pat    <= PAT_OFF;
              r_state  <= DEAD;
            end
          end
          default: begin
            r_state <= IDLE;
            r_pat   <= PAT_OFF;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.top         = r_pat.top;
  assign bus.bot         = r_pat.bot;
  assign bus.plus        = r_pat.plus;
  assign bus.minus       = r_pat.minus;
  assign bus.pause_p     = r_pat.pause_p;
  assign bus.pause_n     = r_pat.pause_n;
  assign bus.busy        = r_busy;
  assign bus.fault       = r_fault;
  assign bus.fault_src   = r_fault_src;
  assign bus.cmd_ignored = r_cmd_ignored;

endmodule

// File: tb/tb_bridge_switch_ctrl.sv
// Directed bench for bridge_switch_ctrl: dead-time timing, retargeting,
// fault filtering and latching, enable drop, ignored codes and async reset.
module tb_bridge_switch_ctrl;
  import bridge_pkg::*;

  localparam logic [11:0] E_OFF   = 12'b0000_0000_0000;
  localparam logic [11:0] E_PLUS  = 12'b0001_0010_1000;
  localparam logic [11:0] E_MINUS = 12'b0010_0001_0100;
  localparam logic [11:0] E_BP    = 12'b0100_1000_0010;
  localparam logic [11:0] E_BN    = 12'b1000_0100_0001;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   n_overlap;
  logic [11:0] w_pat;

  bridge_switch_ctrl_if bus ();

  bridge_switch_ctrl #(.DEADTIME_CYC(50), .ERR_FILT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign w_pat = {bus.top, bus.bot, bus.plus, bus.minus, bus.pause_p, bus.pause_n};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if ((bus.top & bus.bot) != 4'b0000) n_overlap++;
      if ($countones({bus.plus, bus.minus, bus.pause_p, bus.pause_n}) > 1) n_overlap++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [2:0] c);
    bus.cmd       = c;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd       = 3'd0;
  endtask

  // Strobe at cycle N; off N+1..N+50, new pattern at N+51.
  task automatic run_dead(input logic [2:0] c, input logic [11:0] exp, input string tag);
    int bad = 0;
    strobe(c);
    check({tag, " off@N+1"}, 32'(w_pat), 32'(E_OFF));
    check({tag, " busy@N+1"}, 32'(bus.busy), 32'd1);
    repeat (49) begin
      @(negedge clk);
      if (w_pat !== E_OFF || bus.busy !== 1'b1) bad++;
    end
    check({tag, " off+busy thru N+50"}, 32'(bad), 32'd0);
    @(negedge clk);
    check({tag, " pattern@N+51"}, 32'(w_pat), 32'(exp));
    check({tag, " busy@N+51"}, 32'(bus.busy), 32'd0);
  endtask

  logic [2:0]  alt_cmd;
  logic [11:0] alt_exp;
  int          bad_cnt;

  initial begin
    n_checks = 0; n_errors = 0; n_overlap = 0;
    rst = 1'b0;
    bus.enable = 1'b0; bus.cmd_valid = 1'b0; bus.cmd = 3'd0; bus.err_n = '1;
    repeat (3) @(negedge clk);
    check("in reset pattern", 32'(w_pat), 32'(E_OFF));
    rst = 1'b1;
    @(negedge clk);
    check("reset pattern", 32'(w_pat), 32'(E_OFF));
    check("reset busy/fault/ign", 32'({bus.busy, bus.fault, bus.cmd_ignored}), 32'd0);
    check("reset fault_src", 32'(bus.fault_src), 32'd0);
    check("reset state", 32'(dut.r_state), 32'(IDLE));

    bus.enable = 1'b1;
    @(negedge clk);
    strobe(CMD_PAUSE);
    check("idle pause redundant ign", 32'(bus.cmd_ignored), 32'd0);
    check("idle pause redundant busy", 32'(bus.busy), 32'd0);

    run_dead(CMD_PLUS,  E_PLUS,  "plus");
    run_dead(CMD_MINUS, E_MINUS, "minus");

    strobe(CMD_MINUS);
    check("redundant minus pattern", 32'(w_pat), 32'(E_MINUS));
    check("redundant minus ign/busy", 32'({bus.cmd_ignored, bus.busy}), 32'd0);

    for (int i = 0; i < 10; i++) begin
      alt_cmd = (i % 2 == 0) ? CMD_PLUS : CMD_MINUS;
      alt_exp = (i % 2 == 0) ? E_PLUS : E_MINUS;
      strobe(alt_cmd);
      repeat (49) @(negedge clk);
      check($sformatf("alt%0d off@N+50", i), 32'(w_pat), 32'(E_OFF));
      @(negedge clk);
      check($sformatf("alt%0d pattern@N+51", i), 32'(w_pat), 32'(alt_exp));
      repeat (149) @(negedge clk);
    end

    // PLUS at N, BALLAST_N at N+10: counter must not restart.
    strobe(CMD_PLUS);
    repeat (9) @(negedge clk);
    strobe(CMD_BALLAST_N);
    repeat (39) @(negedge clk);
    check("retarget off@N+50", 32'(w_pat), 32'(E_OFF));
    @(negedge clk);
    check("retarget ballast_n@N+51", 32'(w_pat), 32'(E_BN));

    run_dead(CMD_BALLAST_P, E_BP, "ballast_p");

    strobe(CMD_START);
    check("start ignored", 32'(bus.cmd_ignored), 32'd1);
    check("start no change", 32'({w_pat, bus.busy}), 32'({E_BP, 1'b0}));
    @(negedge clk);
    check("ignored is one pulse", 32'(bus.cmd_ignored), 32'd0);
    strobe(CMD_DISCHARGE);
    check("discharge ignored", 32'(bus.cmd_ignored), 32'd1);
    check("discharge no change", 32'({w_pat, bus.busy}), 32'({E_BP, 1'b0}));

    bus.err_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    bus.err_n[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("3-cycle glitch no fault", 32'(bus.fault), 32'd0);
    check("3-cycle glitch pattern", 32'(w_pat), 32'(E_BP));

    bus.err_n[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("fault asserted", 32'(bus.fault), 32'd1);
    check("fault outputs off", 32'({w_pat, bus.busy}), 32'd0);
    check("fault_src err0", 32'(bus.fault_src), 32'b000001);
    strobe(CMD_PLUS);
    check("plus in fault ignored", 32'(bus.cmd_ignored), 32'd1);
    check("plus in fault stays", 32'({bus.fault, w_pat}), 32'({1'b1, E_OFF}));
    strobe(CMD_SHUTDOWN);
    check("shutdown err active ignored", 32'(bus.cmd_ignored), 32'd1);
    check("shutdown err active stays", 32'(bus.fault), 32'd1);
    bus.err_n[5] = 1'b0;
    repeat (4) @(negedge clk);
    check("fault_src accumulates", 32'(bus.fault_src), 32'b100001);
    bus.err_n = '1;
    @(negedge clk);
    strobe(CMD_SHUTDOWN);
    check("shutdown clears fault", 32'({bus.fault, bus.cmd_ignored}), 32'd0);
    check("shutdown clears fault_src", 32'(bus.fault_src), 32'd0);
    check("shutdown to idle", 32'(dut.r_state), 32'(IDLE));

    run_dead(CMD_PLUS, E_PLUS, "plus2");
    bus.enable = 1'b0;
    @(negedge clk);
    check("enable drop off", 32'(w_pat), 32'(E_OFF));
    check("enable drop idle", 32'(dut.r_state), 32'(IDLE));
    strobe(CMD_MINUS);
    check("minus disabled ignored", 32'(bus.cmd_ignored), 32'd1);
    strobe(CMD_PAUSE);
    check("pause disabled silent", 32'(bus.cmd_ignored), 32'd0);
    strobe(CMD_SHUTDOWN);
    check("shutdown disabled silent", 32'(bus.cmd_ignored), 32'd0);
    bus.enable = 1'b1;
    @(negedge clk);

    strobe(CMD_PLUS);
    repeat (10) @(negedge clk);
    check("pre-reset in dead", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async reset mid-dead", 32'({w_pat, bus.busy}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle after reset dead", 32'(dut.r_state), 32'(IDLE));

    run_dead(CMD_MINUS, E_MINUS, "minus2");
    #2 rst = 1'b0;
    #1;
    check("async reset mid-drive", 32'({w_pat, bus.busy}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle after reset drive", 32'(dut.r_state), 32'(IDLE));

    bad_cnt = n_overlap;
    check("no overlap/multi indicator", 32'(bad_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bridge_switch_ctrl.md
Name: bridge_switch_ctrl

Overview:
- Sequences the 4-leg power bridge gate drives (top/bot) and the polarity indicators from decoded command words.
- Inserts a mandatory all-off dead time between any two conducting patterns, then applies the new pattern.
- Latches driver, current and voltage faults, and forces the bridge off until an explicit shutdown clears the fault.
- Sits between the command-strobe decoder and the output pins, alongside the start/charge sequencer, which supplies `enable`.

Parameters:
- DEADTIME_CYC, 50: all-off cycles inserted before any conducting pattern. Must be ≥1; 50 gives 1 µs at a 50 MHz clk.
- ERR_FILT, 4: consecutive low samples needed before an error input counts as asserted. Must be ≥1.
- N_ERR, 6: number of error inputs. Bit order is ERR_DR[4:1], ERR_I, ERR_U.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  bridge permitted to conduct; driven by the start sequencer after precharge.
- cmd_valid  in  1  single-cycle strobe, already synchronised to clk.
- cmd  in  3  command code, qualified by cmd_valid.
- err_n  in  N_ERR  active-low fault inputs, already synchronised.
- top  out  4  high-side gate enables, legs 4..1.
- bot  out  4  low-side gate enables, legs 4..1.
- plus, minus, pause_p, pause_n  out  1 each  indicator for the active pattern.
- busy  out  1  high while in DEAD.
- fault  out  1  high while in FAULT.
- fault_src  out  N_ERR  sticky record of which filtered errors caused or occurred during the fault.
- cmd_ignored  out  1  one-cycle pulse when cmd_valid is not acted on.

Behaviour:
- Reset state: all outputs 0, state IDLE, current pattern = PAUSE, target = PAUSE, counters 0.
- Pattern map. Each code gives {top, bot, indicator}:
  - 0 PAUSE: 0000 / 0000, no indicator.
  - 1 PLUS: 0001 / 0010, plus.
  - 2 MINUS: 0010 / 0001, minus.
  - 3 BALLAST_P: 0100 / 1000, pause_p.
  - 4 BALLAST_N: 1000 / 0100, pause_n.
  - 6 SHUTDOWN: drives as PAUSE.
  - 5 START and 7 DISCHARGE belong to other blocks. Here they give cmd_ignored and no change.
- All outputs are registered. top & bot never share a set bit with each other, and at most one indicator is set, in any cycle.
- States:
  - IDLE: outputs off. An accepted non-pause command (enable=1) sets target, loads the counter with DEADTIME_CYC-1, and goes to DEAD.
  - DEAD: outputs off, busy=1. Counter decrements each cycle. At 0, go to DRIVE with target, or to IDLE if target is PAUSE.
  - DRIVE: outputs = pattern(current).
    - A command whose pattern differs from current sets target and goes to DEAD.
    - Outputs are off from the cycle after cmd_valid.
  - FAULT: outputs off, fault=1.
- Latency: cmd_valid at cycle N. Outputs go off at N+1. The new pattern is visible at N+1+DEADTIME_CYC.
- Redundant commands: a command equal to current in DRIVE, or PAUSE/SHUTDOWN in IDLE, causes no state change and no pulse.
- A command in DEAD replaces target. The counter is not restarted.
- enable=0: any state except FAULT goes to IDLE next cycle with outputs off. Commands with cmd_valid while enable=0 pulse cmd_ignored, except PAUSE and SHUTDOWN, which are accepted silently.
- Error filter: each err_n bit has a saturating counter. Filtered error = counter reached ERR_FILT. A high sample clears that bit's counter.
- Fault entry: any filtered error moves to FAULT from every state. Outputs are off the next cycle. fault_src ORs in every filtered error while in FAULT.
- Simultaneous events: a fault beats a command in the same cycle; that command pulses cmd_ignored.
- Fault exit: only SHUTDOWN, and only while no filtered error is active. Goes to IDLE and clears fault_src and target.
  - SHUTDOWN while an error is still active: stay in FAULT, pulse cmd_ignored.
  - Any other command in FAULT pulses cmd_ignored.
- Mid-operation reset: asynchronous assertion forces the reset state immediately; outputs go off without waiting for clk.

Decomposition:
- bridge_pkg holds:
  - cmd_e enum, codes 0–7;
  - pat_t struct {top[4], bot[4], plus, minus, pause_p, pause_n};
  - function cmd_to_pat;
  - state_e enum {IDLE, DEAD, DRIVE, FAULT};
  - N_ERR localparam.
- Sub-module err_filter: per-bit debounce counter with a filt output, parameterised by ERR_FILT, instantiated N_ERR times via generate.

Test Plan:
- Check after reset release: all outputs 0, state IDLE.
- Gate timing (enable=1, DEADTIME_CYC=50):
  - PLUS at cycle N: top/bot = 0000 from N+1 to N+50, then 0001/0010 with plus=1 at N+51.
  - MINUS next: off at +1, then 0010/0001 with minus=1 at +51.
  - No cycle has overlapping top/bot bits.
- Alternate PLUS/MINUS 10 times with a 200-cycle spacing: pattern correct after each dead time. Then PLUS followed by BALLAST_N 10 cycles later: exactly 1000/0100 with pause_n=1 at 51 cycles after the first strobe.
- Fault filter: err_n[0] low for 3 cycles gives no fault. Low for 4 cycles while in DRIVE:
  - fault=1 and outputs off on the next cycle, fault_src=000001;
  - PLUS then pulses cmd_ignored;
  - SHUTDOWN with err_n still low stays in FAULT;
  - SHUTDOWN after err_n returns high goes to IDLE with fault_src=0.
- enable drop and ignored codes: enable low in DRIVE gives outputs off next cycle. Commands 5 and 7 pulse cmd_ignored with no output change.
- Async reset asserted mid-DEAD and mid-DRIVE: outputs 0 before the next clk edge; IDLE after release.
